// File: rtl/rtr_route_filter_mvc.sv
// Registered multi-VC phased-DOR route filter with sticky/counted error logging.
// Error logging (counters, sticky flags, first-error snapshot) is built only when RTR_ROUTE_FILTER_LOG_EN is defined.
package rtr_route_filter_mvc_pkg;
    localparam int CONNECTIVITY_LINE       = 0;
    localparam int CONNECTIVITY_RING       = 1;
    localparam int CONNECTIVITY_FULL       = 2;
    localparam int ROUTING_TYPE_PHASED_DOR = 0;
    localparam int DIM_ORDER_ASCENDING     = 0;
    localparam int DIM_ORDER_DESCENDING    = 1;
    localparam int DIM_ORDER_BY_CLASS      = 2;
endpackage

module rtr_route_filter_mvc
    import rtr_route_filter_mvc_pkg::*;
#(
    parameter int num_message_classes   = 2,
    parameter int num_resource_classes  = 2,
    parameter int num_vcs_per_class     = 1,
    parameter int num_ports             = 5,
    parameter int num_neighbors_per_dim = 2,
    parameter int num_nodes_per_router  = 1,
    parameter int connectivity          = CONNECTIVITY_LINE,
    parameter int routing_type          = ROUTING_TYPE_PHASED_DOR,
    parameter int dim_order             = DIM_ORDER_ASCENDING,
    parameter int port_id               = 0,
    parameter bit drop_on_error         = 1'b0,
    parameter int err_count_width       = 8,
    parameter int vc_idx_width          =
        (num_message_classes * num_resource_classes * num_vcs_per_class > 1) ?
        $clog2(num_message_classes * num_resource_classes * num_vcs_per_class) : 1
) (
    input  logic                            clk,
    input  logic                            reset_n,
    input  logic                            route_valid,
    input  logic [vc_idx_width-1:0]         route_vc,
    input  logic [0:num_ports-1]            route_in_op,
    input  logic [0:num_resource_classes-1] route_in_orc,
    input  logic                            err_clear,
    output logic                            route_out_valid,
    output logic [vc_idx_width-1:0]         route_out_vc,
    output logic [0:num_ports-1]            route_out_op,
    output logic [0:num_resource_classes-1] route_out_orc,
    output logic [0:1]                      errors,
    output logic [0:1]                      err_sticky,
    output logic [err_count_width-1:0]      err_port_count,
    output logic [err_count_width-1:0]      err_class_count,
    output logic [vc_idx_width-1:0]         err_first_vc,
    output logic [0:num_ports-1]            err_first_op,
    output logic [0:num_resource_classes-1] err_first_orc
);

    localparam int num_net_ports = num_ports - num_nodes_per_router;
    localparam int nbr           = num_neighbors_per_dim;
    localparam bit port_is_net   = (port_id < num_net_ports);
    localparam bit dor_en        = (routing_type == ROUTING_TYPE_PHASED_DOR);

    logic [0:num_ports-1]            op_allow_s;
    logic [0:num_resource_classes-1] orc_allow_s;
    logic [0:num_ports-1]            op_masked_s;
    logic [0:num_resource_classes-1] orc_masked_s;
    logic                            last_s;
    logic                            forbid_lo_s;
    logic                            forbid_hi_s;
    logic                            port_err_s;
    logic                            class_err_s;
    logic                            out_valid_d;
    int                              rc_s;
    int                              mc_s;

    logic                            valid_q;
    logic [vc_idx_width-1:0]         vc_q;
    logic [0:num_ports-1]            op_q;
    logic [0:num_resource_classes-1] orc_q;
    logic [0:1]                      errors_q;

    // Decode the flit's classes from its VC and build the per-port and per-class allow masks
    always_comb begin
        rc_s        = (int'(route_vc) / num_vcs_per_class) % num_resource_classes;
        mc_s        = (int'(route_vc) / (num_resource_classes * num_vcs_per_class)) % num_message_classes;
        last_s      = (rc_s == num_resource_classes - 1);
        forbid_lo_s = 1'b0;
        forbid_hi_s = 1'b0;
        op_allow_s  = '1;
        orc_allow_s = '0;
        if (dim_order == DIM_ORDER_ASCENDING) begin
            forbid_lo_s = 1'b1;
        end else if (dim_order == DIM_ORDER_DESCENDING) begin
            forbid_hi_s = 1'b1;
        end else if (dim_order == DIM_ORDER_BY_CLASS) begin
            forbid_lo_s = ((mc_s % 2) == 0);
            forbid_hi_s = ((mc_s % 2) != 0);
        end else begin
            forbid_lo_s = 1'b0;
            forbid_hi_s = 1'b0;
        end
        for (int i = 0; i < num_ports; i++) begin
            if (i < num_net_ports) begin
                if (!last_s) begin
                    op_allow_s[i] = 1'b1;
                end else if ((connectivity != CONNECTIVITY_FULL) && (i == port_id)) begin
                    op_allow_s[i] = 1'b0;
                end else if ((connectivity == CONNECTIVITY_FULL) && ((i / nbr) == (port_id / nbr))) begin
                    op_allow_s[i] = 1'b0;
                end else if (dor_en && port_is_net && forbid_lo_s && ((i / nbr) < (port_id / nbr))) begin
                    op_allow_s[i] = 1'b0;
                end else if (dor_en && port_is_net && forbid_hi_s && ((i / nbr) > (port_id / nbr))) begin
                    op_allow_s[i] = 1'b0;
                end else begin
                    op_allow_s[i] = 1'b1;
                end
            end else begin
                op_allow_s[i] = (i != port_id);
            end
        end
        for (int j = 0; j < num_resource_classes; j++) begin
            orc_allow_s[j] = (j == rc_s) || (j == rc_s + 1);
        end
    end

    assign op_masked_s = route_in_op & op_allow_s;
    assign port_err_s  = route_valid & ((|(route_in_op & ~op_allow_s)) | ~(|route_in_op));

    // A single resource class always resolves to that class and can never be in error
    if (num_resource_classes == 1) begin : g_one_rc
        assign orc_masked_s = '1;
        assign class_err_s  = 1'b0;
    end else begin : g_multi_rc
        assign orc_masked_s = route_in_orc & orc_allow_s;
        assign class_err_s  = route_valid & ((|(route_in_orc & ~orc_allow_s)) | ~(|route_in_orc));
    end

    assign out_valid_d = route_valid & ~(drop_on_error & (port_err_s | class_err_s));

    // Output pipeline stage: route is zeroed whenever it is not presented as valid
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            valid_q  <= 1'b0;
            vc_q     <= '0;
            op_q     <= '0;
            orc_q    <= '0;
            errors_q <= 2'b00;
        end else begin
            valid_q  <= out_valid_d;
            vc_q     <= route_vc;
            op_q     <= out_valid_d ? op_masked_s : '0;
            orc_q    <= out_valid_d ? orc_masked_s : '0;
            errors_q <= {port_err_s, class_err_s};
        end
    end

    assign route_out_valid = valid_q;
    assign route_out_vc    = vc_q;
    assign route_out_op    = op_q;
    assign route_out_orc   = orc_q;
    assign errors          = errors_q;

`ifdef RTR_ROUTE_FILTER_LOG_EN
    localparam logic [err_count_width-1:0] cnt_one = err_count_width'(1);

    logic [err_count_width-1:0]      port_cnt_q,  port_cnt_d;
    logic [err_count_width-1:0]      class_cnt_q, class_cnt_d;
    logic [0:1]                      sticky_q,    sticky_d;
    logic [vc_idx_width-1:0]         first_vc_q,  first_vc_d;
    logic [0:num_ports-1]            first_op_q,  first_op_d;
    logic [0:num_resource_classes-1] first_orc_q, first_orc_d;
    logic                            load_snap_s;

    function automatic logic [err_count_width-1:0] sat_inc(
        input logic [err_count_width-1:0] cnt,
        input logic                       inc
    );
        if (inc && (cnt != '1)) begin
            sat_inc = cnt + cnt_one;
        end else begin
            sat_inc = cnt;
        end
    endfunction

    // Clear takes effect first, then this cycle's errors are folded into the cleared state
    always_comb begin
        if (err_clear) begin
            port_cnt_d  = '0;
            class_cnt_d = '0;
            sticky_d    = 2'b00;
            first_vc_d  = '0;
            first_op_d  = '0;
            first_orc_d = '0;
        end else begin
            port_cnt_d  = port_cnt_q;
            class_cnt_d = class_cnt_q;
            sticky_d    = sticky_q;
            first_vc_d  = first_vc_q;
            first_op_d  = first_op_q;
            first_orc_d = first_orc_q;
        end
        load_snap_s = (sticky_d == 2'b00) && (port_err_s || class_err_s);
        if (load_snap_s) begin
            first_vc_d  = route_vc;
            first_op_d  = route_in_op;
            first_orc_d = route_in_orc;
        end else begin
            first_vc_d  = first_vc_d;
        end
        port_cnt_d  = sat_inc(port_cnt_d, port_err_s);
        class_cnt_d = sat_inc(class_cnt_d, class_err_s);
        sticky_d    = sticky_d | {port_err_s, class_err_s};
    end

    // Error log state
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            port_cnt_q  <= '0;
            class_cnt_q <= '0;
            sticky_q    <= 2'b00;
            first_vc_q  <= '0;
            first_op_q  <= '0;
            first_orc_q <= '0;
        end else begin
            port_cnt_q  <= port_cnt_d;
            class_cnt_q <= class_cnt_d;
            sticky_q    <= sticky_d;
            first_vc_q  <= first_vc_d;
            first_op_q  <= first_op_d;
            first_orc_q <= first_orc_d;
        end
    end

    assign err_sticky      = sticky_q;
    assign err_port_count  = port_cnt_q;
    assign err_class_count = class_cnt_q;
    assign err_first_vc    = first_vc_q;
    assign err_first_op    = first_op_q;
    assign err_first_orc   = first_orc_q;
`else
    logic unused_err_clear_s;

    assign unused_err_clear_s = err_clear;
    assign err_sticky         = 2'b00;
    assign err_port_count     = '0;
    assign err_class_count    = '0;
    assign err_first_vc       = '0;
    assign err_first_op       = '0;
    assign err_first_orc      = '0;
`endif

endmodule

// File: tb/tb_rtr_route_filter_mvc.sv
// Directed bench for rtr_route_filter_mvc: default filter, 2-bit saturating counters, and drop_on_error.
module tb_rtr_route_filter_mvc;

`ifdef RTR_ROUTE_FILTER_LOG_EN
    localparam bit LOG = 1'b1;
`else
    localparam bit LOG = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset_n;
    logic       route_valid;
    logic [1:0] route_vc;
    logic [0:4] route_in_op;
    logic [0:1] route_in_orc;
    logic       err_clear;

    logic       m_valid, s_valid, d_valid;
    logic [1:0] m_vc, s_vc, d_vc;
    logic [0:4] m_op, s_op, d_op;
    logic [0:1] m_orc, s_orc, d_orc;
    logic [0:1] m_errs, s_errs, d_errs;
    logic [0:1] m_sticky, s_sticky, d_sticky;
    logic [7:0] m_pc, m_cc, d_pc, d_cc;
    logic [1:0] s_pc, s_cc;
    logic [1:0] m_fvc, s_fvc, d_fvc;
    logic [0:4] m_fop, s_fop, d_fop;
    logic [0:1] m_forc, s_forc, d_forc;

    int checks_cnt = 0;
    int errors_cnt = 0;

    always #5 clk = ~clk;

    rtr_route_filter_mvc #(.port_id(2)) u_main (
        .clk(clk), .reset_n(reset_n), .route_valid(route_valid), .route_vc(route_vc),
        .route_in_op(route_in_op), .route_in_orc(route_in_orc), .err_clear(err_clear),
        .route_out_valid(m_valid), .route_out_vc(m_vc), .route_out_op(m_op), .route_out_orc(m_orc),
        .errors(m_errs), .err_sticky(m_sticky), .err_port_count(m_pc), .err_class_count(m_cc),
        .err_first_vc(m_fvc), .err_first_op(m_fop), .err_first_orc(m_forc));

    rtr_route_filter_mvc #(.port_id(2), .err_count_width(2)) u_sat (
        .clk(clk), .reset_n(reset_n), .route_valid(route_valid), .route_vc(route_vc),
        .route_in_op(route_in_op), .route_in_orc(route_in_orc), .err_clear(err_clear),
        .route_out_valid(s_valid), .route_out_vc(s_vc), .route_out_op(s_op), .route_out_orc(s_orc),
        .errors(s_errs), .err_sticky(s_sticky), .err_port_count(s_pc), .err_class_count(s_cc),
        .err_first_vc(s_fvc), .err_first_op(s_fop), .err_first_orc(s_forc));

    rtr_route_filter_mvc #(.port_id(2), .drop_on_error(1'b1)) u_drop (
        .clk(clk), .reset_n(reset_n), .route_valid(route_valid), .route_vc(route_vc),
        .route_in_op(route_in_op), .route_in_orc(route_in_orc), .err_clear(err_clear),
        .route_out_valid(d_valid), .route_out_vc(d_vc), .route_out_op(d_op), .route_out_orc(d_orc),
        .errors(d_errs), .err_sticky(d_sticky), .err_port_count(d_pc), .err_class_count(d_cc),
        .err_first_vc(d_fvc), .err_first_op(d_fop), .err_first_orc(d_forc));

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks_cnt++;
        if (act !== exp) begin
            errors_cnt++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic logic [31:0] lg(input logic [31:0] v);
        return LOG ? v : 32'd0;
    endfunction

    // Drive one cycle of inputs; on return the registered outputs reflect them
    task automatic flit(input logic v, input logic [1:0] vc, input logic [0:4] op,
                        input logic [0:1] orc, input logic clr);
        route_valid  = v;
        route_vc     = vc;
        route_in_op  = op;
        route_in_orc = orc;
        err_clear    = clr;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset_n     = 1'b0;
        route_valid = 1'b0;
        err_clear   = 1'b0;
        @(posedge clk);
        #1;
        reset_n = 1'b1;
    endtask

    task automatic chk_main(input string tag, input logic v, input logic [0:4] op,
                            input logic [0:1] orc, input logic [0:1] e, input logic [7:0] pc,
                            input logic [7:0] cc);
        chk({tag, ".valid"}, 32'(m_valid), 32'(v));
        chk({tag, ".op"},    32'(m_op),    32'(op));
        chk({tag, ".orc"},   32'(m_orc),   32'(orc));
        chk({tag, ".errs"},  32'(m_errs),  32'(e));
        chk({tag, ".pc"},    32'(m_pc),    lg(32'(pc)));
        chk({tag, ".cc"},    32'(m_cc),    lg(32'(cc)));
    endtask

    task automatic chk_snap(input string tag, input logic [0:1] st, input logic [1:0] vc,
                            input logic [0:4] op, input logic [0:1] orc);
        chk({tag, ".sticky"}, 32'(m_sticky), lg(32'(st)));
        chk({tag, ".fvc"},    32'(m_fvc),    lg(32'(vc)));
        chk({tag, ".fop"},    32'(m_fop),    lg(32'(op)));
        chk({tag, ".forc"},   32'(m_forc),   lg(32'(orc)));
    endtask

    initial begin
        reset_n      = 1'b0;
        route_valid  = 1'b0;
        route_vc     = 2'd0;
        route_in_op  = 5'b00000;
        route_in_orc = 2'b00;
        err_clear    = 1'b0;

        // Reset held with random inputs: everything stays at zero
        for (int i = 0; i < 4; i++) begin
            route_valid  = 1'($urandom);
            route_vc     = 2'($urandom_range(3));
            route_in_op  = 5'($urandom);
            route_in_orc = 2'($urandom);
            err_clear    = 1'($urandom);
            @(posedge clk);
            #1;
            chk_main("rst", 1'b0, 5'b00000, 2'b00, 2'b00, 8'd0, 8'd0);
            chk_snap("rst", 2'b00, 2'd0, 5'b00000, 2'b00);
        end
        reset_n = 1'b1;
        flit(1'b0, 2'd1, 5'b10000, 2'b00, 1'b0);
        chk_main("post_rst", 1'b0, 5'b00000, 2'b00, 2'b00, 8'd0, 8'd0);

        // vc0: rc0, not last -> network ops unrestricted; op3 and orc1 legal
        flit(1'b1, 2'd0, 5'b00010, 2'b01, 1'b0);
        chk_main("legal", 1'b1, 5'b00010, 2'b01, 2'b00, 8'd0, 8'd0);
        chk("legal.vc", 32'(m_vc), 32'd0);
        // vc1: rc1 last, mc0; ascending masks ops 0,1 and op==port_id 2
        flit(1'b1, 2'd1, 5'b10000, 2'b01, 1'b0);
        chk_main("op0", 1'b1, 5'b00000, 2'b01, 2'b10, 8'd1, 8'd0);
        chk("op0.vc", 32'(m_vc), 32'd1);
        chk_snap("op0", 2'b10, 2'd1, 5'b10000, 2'b01);
        flit(1'b1, 2'd1, 5'b00100, 2'b01, 1'b0);
        chk_main("op_self", 1'b1, 5'b00000, 2'b01, 2'b10, 8'd2, 8'd0);
        chk_snap("op_self", 2'b10, 2'd1, 5'b10000, 2'b01);
        // op3 shares port_id's dimension group and op4 is a node port: both pass
        flit(1'b1, 2'd1, 5'b00011, 2'b01, 1'b0);
        chk_main("op34", 1'b1, 5'b00011, 2'b01, 2'b00, 8'd2, 8'd0);
        flit(1'b1, 2'd2, 5'b11100, 2'b11, 1'b0);
        chk_main("vc2", 1'b1, 5'b11100, 2'b11, 2'b00, 8'd2, 8'd0);
        flit(1'b1, 2'd3, 5'b01011, 2'b01, 1'b0);
        chk_main("vc3", 1'b1, 5'b00011, 2'b01, 2'b10, 8'd3, 8'd0);
        flit(1'b1, 2'd0, 5'b00000, 2'b01, 1'b0);
        chk_main("op_zero", 1'b1, 5'b00000, 2'b01, 2'b10, 8'd4, 8'd0);
        // vc1 (rc1): orc0 masked, orc1 passes
        flit(1'b1, 2'd1, 5'b00010, 2'b10, 1'b0);
        chk_main("orc0", 1'b1, 5'b00010, 2'b00, 2'b01, 8'd4, 8'd1);
        chk_snap("orc0", 2'b11, 2'd1, 5'b10000, 2'b01);
        flit(1'b1, 2'd1, 5'b00010, 2'b01, 1'b0);
        chk_main("orc1", 1'b1, 5'b00010, 2'b01, 2'b00, 8'd4, 8'd1);
        flit(1'b1, 2'd0, 5'b00010, 2'b00, 1'b0);
        chk_main("orc_zero", 1'b1, 5'b00010, 2'b00, 2'b01, 8'd4, 8'd2);
        // Invalid input carrying an illegal request raises nothing
        flit(1'b0, 2'd1, 5'b10000, 2'b00, 1'b0);
        chk_main("idle", 1'b0, 5'b00000, 2'b00, 2'b00, 8'd4, 8'd2);
        flit(1'b0, 2'd0, 5'b00000, 2'b00, 1'b1);
        chk_main("clear", 1'b0, 5'b00000, 2'b00, 2'b00, 8'd0, 8'd0);
        chk_snap("clear", 2'b00, 2'd0, 5'b00000, 2'b00);
        // Clear coincident with an error: the new error is logged after clearing
        flit(1'b1, 2'd1, 5'b00001, 2'b01, 1'b0);
        flit(1'b1, 2'd1, 5'b10000, 2'b10, 1'b0);
        flit(1'b1, 2'd3, 5'b00100, 2'b01, 1'b1);
        chk_main("clr_err", 1'b1, 5'b00000, 2'b01, 2'b10, 8'd1, 8'd0);
        chk_snap("clr_err", 2'b10, 2'd3, 5'b00100, 2'b01);

        // Asynchronous reset mid-stream drops the presented flit immediately
        flit(1'b1, 2'd0, 5'b00010, 2'b01, 1'b0);
        reset_n = 1'b0;
        #1;
        chk("mid_rst.valid", 32'(m_valid), 32'd0);
        chk("mid_rst.op", 32'(m_op), 32'd0);
        chk("mid_rst.pc", 32'(m_pc), 32'd0);
        do_reset();

        // 2-bit counter saturates at 3
        for (int i = 1; i <= 5; i++) begin
            flit(1'b1, 2'd1, 5'b10000, 2'b01, 1'b0);
            chk($sformatf("sat%0d", i), 32'(s_pc), lg((i > 3) ? 32'd3 : 32'(i)));
        end
        chk("sat.cc", 32'(s_cc), 32'd0);
        flit(1'b1, 2'd3, 5'b00100, 2'b01, 1'b1);
        chk("sat_clr.pc", 32'(s_pc), lg(32'd1));
        chk("sat_clr.fvc", 32'(s_fvc), lg(32'd3));
        chk("sat_clr.fop", 32'(s_fop), lg(32'(5'b00100)));
        chk("sat_clr.sticky", 32'(s_sticky), lg(32'(2'b10)));
        do_reset();

        // drop_on_error: erroneous flits are suppressed but still pulse errors
        flit(1'b1, 2'd1, 5'b10000, 2'b01, 1'b0);
        chk("drop.valid", 32'(d_valid), 32'd0);
        chk("drop.op", 32'(d_op), 32'd0);
        chk("drop.errs", 32'(d_errs), 32'(2'b10));
        flit(1'b1, 2'd0, 5'b00010, 2'b01, 1'b0);
        chk("b2b0.valid", 32'(d_valid), 32'd1);
        chk("b2b0.op", 32'(d_op), 32'(5'b00010));
        chk("b2b0.errs", 32'(d_errs), 32'd0);
        flit(1'b1, 2'd1, 5'b00001, 2'b01, 1'b0);
        chk("b2b1.valid", 32'(d_valid), 32'd1);
        chk("b2b1.op", 32'(d_op), 32'(5'b00001));
        flit(1'b1, 2'd2, 5'b01000, 2'b01, 1'b0);
        chk("b2b2.valid", 32'(d_valid), 32'd1);
        chk("b2b2.op", 32'(d_op), 32'(5'b01000));
        chk("b2b2.vc", 32'(d_vc), 32'd2);
        flit(1'b1, 2'd1, 5'b00010, 2'b10, 1'b0);
        chk("drop_cls.valid", 32'(d_valid), 32'd0);
        chk("drop_cls.orc", 32'(d_orc), 32'd0);
        chk("drop_cls.errs", 32'(d_errs), 32'(2'b01));
        flit(1'b0, 2'd0, 5'b00000, 2'b00, 1'b0);
        chk("drop_idle.errs", 32'(d_errs), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks_cnt, errors_cnt);
        $finish;
    end

endmodule
